// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a 32x8 synchronous memory.
// Issues one single-beat memory command at a time and steers read data back to its requester.
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_e;

  state_e              state_q;
  logic                prio_q;
  logic                owner_q;
  logic                isRead_q;
  logic                gnt0_q, gnt1_q;
  logic                rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;
  logic                read_q, write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   dataIn_q;
  logic                busy_q;

  // Port 1 wins when it is the only requester, or when both request and it holds priority.
  logic pickPort1_d;
  assign pickPort1_d = req1 & (~req0 | prio_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      isRead_q  <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      dataIn_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            state_q <= ACCESS;
            busy_q  <= 1'b1;
            owner_q <= pickPort1_d;
            prio_q  <= ~pickPort1_d;
            gnt0_q  <= ~pickPort1_d;
            gnt1_q  <= pickPort1_d;
            if (pickPort1_d) begin
              read_q   <= ~we1;
              write_q  <= we1;
              isRead_q <= ~we1;
              addr_q   <= addr1;
              dataIn_q <= we1 ? wdata1 : '0;
            end else begin
              read_q   <= ~we0;
              write_q  <= we0;
              isRead_q <= ~we0;
              addr_q   <= addr0;
              dataIn_q <= we0 ? wdata0 : '0;
            end
          end
        end
        ACCESS: begin
          if (isRead_q) begin
            state_q <= RDWAIT;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RDWAIT: begin
          // Memory drives data_out during this cycle for the read sampled at the end of ACCESS.
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (owner_q) begin
            rdata1_q  <= data_out;
            rvalid1_q <= 1'b1;
          end else begin
            rdata0_q  <= data_out;
            rvalid0_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign read    = read_q;
  assign write   = write_q;
  assign addr    = addr_q;
  assign data_in = dataIn_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of per-cycle vectors plus
// hand-written multi-cycle sequences, with a behavioural 32x8 synchronous memory.
module tb_mem_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic              gnt0, gnt1, rvalid0, rvalid1, read, write, busy;
  logic [DATA_W-1:0] rdata0, rdata1, data_in;
  logic [DATA_W-1:0] data_out = '0;
  logic [ADDR_W-1:0] addr;

  logic [DATA_W-1:0] mem [32];

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .read(read), .write(write), .addr(addr), .data_in(data_in),
    .data_out(data_out), .busy(busy)
  );

  // Memory model: samples strobes on the rising edge, read data appears the following cycle.
  always @(posedge clk) begin
    if (write) mem[addr] <= data_in;
    if (read) data_out <= mem[addr];
  end

  typedef struct {
    logic              r0, w0;
    logic [ADDR_W-1:0] a0;
    logic [DATA_W-1:0] d0;
    logic              r1, w1;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] d1;
    logic [6:0]        ctrl;
    logic [ADDR_W-1:0] expAddr;
    logic [DATA_W-1:0] expDin, expRd0, expRd1;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic r0, input logic w0, input logic [4:0] a0, input logic [7:0] d0,
                              input logic r1, input logic w1, input logic [4:0] a1, input logic [7:0] d1,
                              input logic [6:0] ctrl, input logic [4:0] ea, input logic [7:0] ed,
                              input logic [7:0] er0, input logic [7:0] er1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.ctrl = ctrl; v.expAddr = ea; v.expDin = ed; v.expRd0 = er0; v.expRd1 = er1;
    return v;
  endfunction

  function automatic logic [6:0] ctrlBits();
    return {gnt0, gnt1, read, write, rvalid0, rvalid1, busy};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearReqs();
    req0 = 1'b0; req1 = 1'b0;
  endtask

  // which: 0 = gnt0, 1 = gnt1, 2 = rvalid1
  task automatic waitFor(input int which, input int maxCycles, output bit got);
    got = 1'b0;
    for (int c = 0; c < maxCycles && !got; c++) begin
      stepCycle();
      case (which)
        0: got = gnt0;
        1: got = gnt1;
        default: got = rvalid1;
      endcase
    end
  endtask

  initial begin
    bit got;
    int rvSeen;
    int order[$];
    int rv0Cnt, rv1Cnt, clash;
    logic [4:0] a;
    logic [7:0] expData;

    for (int i = 0; i < 32; i++) mem[i] = '0;

    // ctrl = {gnt0, gnt1, read, write, rvalid0, rvalid1, busy}
    vecs[0]  = mk(1,1,3,8'hA5, 0,0,0,8'h00, 7'b1001001, 3, 8'hA5, 8'h00, 8'h00);
    vecs[1]  = mk(0,0,0,8'h00, 0,0,0,8'h00, 7'b0000000, 3, 8'hA5, 8'h00, 8'h00);
    vecs[2]  = mk(1,0,3,8'h00, 0,0,0,8'h00, 7'b1010001, 3, 8'h00, 8'h00, 8'h00);
    vecs[3]  = mk(0,0,0,8'h00, 0,0,0,8'h00, 7'b0000001, 3, 8'h00, 8'h00, 8'h00);
    vecs[4]  = mk(0,0,0,8'h00, 0,0,0,8'h00, 7'b0000100, 3, 8'h00, 8'hA5, 8'h00);
    vecs[5]  = mk(0,0,0,8'h00, 1,1,9,8'h3C, 7'b0101001, 9, 8'h3C, 8'hA5, 8'h00);
    vecs[6]  = mk(0,0,0,8'h00, 0,0,0,8'h00, 7'b0000000, 9, 8'h3C, 8'hA5, 8'h00);
    vecs[7]  = mk(1,1,7,8'h11, 1,0,7,8'hFF, 7'b1001001, 7, 8'h11, 8'hA5, 8'h00);
    vecs[8]  = mk(0,0,0,8'h00, 1,0,7,8'hFF, 7'b0000000, 7, 8'h11, 8'hA5, 8'h00);
    vecs[9]  = mk(0,0,0,8'h00, 1,0,7,8'hFF, 7'b0110001, 7, 8'h00, 8'hA5, 8'h00);
    vecs[10] = mk(0,0,0,8'h00, 0,0,0,8'h00, 7'b0000001, 7, 8'h00, 8'hA5, 8'h00);
    vecs[11] = mk(0,0,0,8'h00, 0,0,0,8'h00, 7'b0000010, 7, 8'h00, 8'hA5, 8'h11);
    vecs[12] = mk(0,0,0,8'h00, 1,0,3,8'h00, 7'b0110001, 3, 8'h00, 8'hA5, 8'h11);
    vecs[13] = mk(1,1,5,8'hEE, 0,0,0,8'h00, 7'b0000001, 3, 8'h00, 8'hA5, 8'h11);
    vecs[14] = mk(0,0,0,8'h00, 0,0,0,8'h00, 7'b0000010, 3, 8'h00, 8'hA5, 8'hA5);
    vecs[15] = mk(0,0,0,8'h00, 0,0,0,8'h00, 7'b0000000, 3, 8'h00, 8'hA5, 8'hA5);

    // Reset state
    #2 rst_n = 1'b0;
    #2;
    checkOutput("reset ctrl", ctrlBits(), 7'b0);
    checkOutput("reset addr", addr, 0);
    checkOutput("reset data_in", data_in, 0);
    checkOutput("reset rdata0", rdata0, 0);
    checkOutput("reset rdata1", rdata1, 0);
    stepCycle();
    stepCycle();
    rst_n = 1'b1;

    // Per-cycle vectors: write/read on port 0, contention with prio 0, dropped req during access
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      stepCycle();
      checkOutput($sformatf("vec%0d ctrl", i), ctrlBits(), vecs[i].ctrl);
      checkOutput($sformatf("vec%0d addr", i), addr, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d data_in", i), data_in, vecs[i].expDin);
      checkOutput($sformatf("vec%0d rdata0", i), rdata0, vecs[i].expRd0);
      checkOutput($sformatf("vec%0d rdata1", i), rdata1, vecs[i].expRd1);
    end
    checkOutput("dropped req0 no write to mem[5]", mem[5], 0);
    clearReqs();

    // Port 1 alone: fill all 32 locations, then read back starting at 31 to cover rollover
    for (int k = 0; k < 32; k++) begin
      a = 5'(k);
      req1 = 1'b1; we1 = 1'b1; addr1 = a; wdata1 = 8'(k) ^ 8'h5A;
      waitFor(1, 4, got);
      checkOutput($sformatf("wr%0d gnt1", k), got, 1);
      checkOutput($sformatf("wr%0d strobe", k), {read, write}, 2'b01);
      checkOutput($sformatf("wr%0d addr", k), addr, a);
      checkOutput($sformatf("wr%0d data_in", k), data_in, 8'(k) ^ 8'h5A);
    end
    req1 = 1'b0;
    stepCycle();
    for (int k = 0; k < 32; k++) begin
      a = 5'((k + 31) % 32);
      expData = {3'b000, a} ^ 8'h5A;
      req1 = 1'b1; we1 = 1'b0; addr1 = a;
      waitFor(1, 4, got);
      checkOutput($sformatf("rd%0d gnt1", k), got, 1);
      req1 = 1'b0;
      waitFor(2, 4, got);
      checkOutput($sformatf("rd%0d rvalid1", k), got, 1);
      checkOutput($sformatf("rd%0d rdata1", k), rdata1, expData);
    end
    stepCycle();

    // Reset in the middle of a port 0 read
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
    stepCycle();
    checkOutput("midrst read issued", ctrlBits(), 7'b1010001);
    req0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst ctrl", ctrlBits(), 7'b0);
    checkOutput("midrst addr", addr, 0);
    checkOutput("midrst rdata1", rdata1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rvSeen = 0;
    for (int c = 0; c < 6; c++) begin
      stepCycle();
      if (rvalid0 || rvalid1) rvSeen++;
    end
    checkOutput("midrst no rvalid", rvSeen, 0);
    checkOutput("midrst rdata0", rdata0, 0);

    // Both ports hold reads from reset: alternation and data steering
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd31;
    stepCycle();
    rst_n = 1'b1;
    rv0Cnt = 0; rv1Cnt = 0; clash = 0;
    for (int c = 0; c < 13; c++) begin
      stepCycle();
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
      if ((gnt0 && gnt1) || (read && write) || (rvalid0 && rvalid1)) clash++;
      if (rvalid0) begin
        rv0Cnt++;
        checkOutput($sformatf("rr rdata0 c%0d", c), rdata0, 8'h5A);
      end
      if (rvalid1) begin
        rv1Cnt++;
        checkOutput($sformatf("rr rdata1 c%0d", c), rdata1, 8'h45);
      end
    end
    clearReqs();
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("rr grant %0d", i), (i < order.size()) ? order[i] : 9, i % 2);
    checkOutput("rr rvalid0 count", rv0Cnt, 2);
    checkOutput("rr rvalid1 count", rv1Cnt, 2);
    checkOutput("rr exclusivity", clash, 0);
    stepCycle();
    stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
